// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : Pipeline stage 3 of the RISC-V core. Executes loads and stores
//            over a 64-bit req/ack bus and passes every other instruction
//            through with its ALU result. One instruction in flight.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int BUS_DATA_WIDTH         = 64,
    parameter int REGISTER_NUMBER_WIDTH  = 5,
    parameter int REGISTER_WIDTH         = 64,
    parameter int INSTRUCTION_NAME_WIDTH = 12
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  stage3_valid,
    output logic                                  stage3_ready,
    input  logic [REGISTER_WIDTH-1:0]             stage3_alu_result,
    input  logic [REGISTER_WIDTH-1:0]             stage3_rs2_val,
    input  logic [REGISTER_NUMBER_WIDTH:0]        stage3_rd,
    input  logic [INSTRUCTION_NAME_WIDTH*8:0]     stage3_opcode_name,
    input  logic [BUS_DATA_WIDTH-1:0]             stage3_pc,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [BUS_DATA_WIDTH-1:0]             mem_addr,
    output logic [63:0]                           mem_wdata,
    output logic [7:0]                            mem_wstrb,
    input  logic                                  mem_ack,
    input  logic [63:0]                           mem_rdata,
    output logic                                  nstage4_valid,
    input  logic                                  wb_ready,
    output logic [REGISTER_WIDTH-1:0]             nstage4_result,
    output logic [REGISTER_NUMBER_WIDTH:0]        nstage4_rd,
    output logic [INSTRUCTION_NAME_WIDTH*8:0]     nstage4_opcode_name,
    output logic [BUS_DATA_WIDTH-1:0]             nstage4_pc,
    output logic                                  nstage4_misaligned
);

    localparam int c_name_w = INSTRUCTION_NAME_WIDTH*8+1;

    // Opcode names are right-justified ASCII, zero padded on the left.
    localparam logic [c_name_w-1:0] c_op_lb  = {{(c_name_w-16){1'b0}}, "lb"};
    localparam logic [c_name_w-1:0] c_op_lh  = {{(c_name_w-16){1'b0}}, "lh"};
    localparam logic [c_name_w-1:0] c_op_lw  = {{(c_name_w-16){1'b0}}, "lw"};
    localparam logic [c_name_w-1:0] c_op_ld  = {{(c_name_w-16){1'b0}}, "ld"};
    localparam logic [c_name_w-1:0] c_op_lbu = {{(c_name_w-24){1'b0}}, "lbu"};
    localparam logic [c_name_w-1:0] c_op_lhu = {{(c_name_w-24){1'b0}}, "lhu"};
    localparam logic [c_name_w-1:0] c_op_lwu = {{(c_name_w-24){1'b0}}, "lwu"};
    localparam logic [c_name_w-1:0] c_op_sb  = {{(c_name_w-16){1'b0}}, "sb"};
    localparam logic [c_name_w-1:0] c_op_sh  = {{(c_name_w-16){1'b0}}, "sh"};
    localparam logic [c_name_w-1:0] c_op_sw  = {{(c_name_w-16){1'b0}}, "sw"};
    localparam logic [c_name_w-1:0] c_op_sd  = {{(c_name_w-16){1'b0}}, "sd"};

    // Access size code: 0=byte, 1=half, 2=word, 3=double.
    localparam logic [1:0] c_size_b = 2'd0;
    localparam logic [1:0] c_size_h = 2'd1;
    localparam logic [1:0] c_size_w = 2'd2;
    localparam logic [1:0] c_size_d = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_signed;
    logic [1:0]  w_size;
    logic [2:0]  w_offset;
    logic [3:0]  w_bytes;
    logic [3:0]  w_end;
    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_go_bus;
    logic        w_accept;
    logic [7:0]  w_strb_base;
    logic [63:0] w_store_wdata;
    logic [63:0] w_rdata_shifted;
    logic [63:0] w_load_value;

    // Load formatting needs only these once the bus is in progress.
    logic [2:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_is_load;

    assign stage3_ready = (r_state == S_IDLE);
    assign w_accept     = stage3_ready && stage3_valid;

    // Decode the opcode string into access kind, size and signedness.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = c_size_b;
        case (stage3_opcode_name)
            c_op_lb:  begin w_is_load = 1'b1; w_size = c_size_b; w_signed = 1'b1; end
            c_op_lh:  begin w_is_load = 1'b1; w_size = c_size_h; w_signed = 1'b1; end
            c_op_lw:  begin w_is_load = 1'b1; w_size = c_size_w; w_signed = 1'b1; end
            c_op_ld:  begin w_is_load = 1'b1; w_size = c_size_d; end
            c_op_lbu: begin w_is_load = 1'b1; w_size = c_size_b; end
            c_op_lhu: begin w_is_load = 1'b1; w_size = c_size_h; end
            c_op_lwu: begin w_is_load = 1'b1; w_size = c_size_w; end
            c_op_sb:  begin w_is_store = 1'b1; w_size = c_size_b; end
            c_op_sh:  begin w_is_store = 1'b1; w_size = c_size_h; end
            c_op_sw:  begin w_is_store = 1'b1; w_size = c_size_w; end
            c_op_sd:  begin w_is_store = 1'b1; w_size = c_size_d; end
            default:  ;
        endcase
    end

    // An access is misaligned when it spills past the end of its 8-byte word.
    assign w_offset     = stage3_alu_result[2:0];
    assign w_bytes      = 4'd1 << w_size;
    assign w_end        = {1'b0, w_offset} + w_bytes;
    assign w_mem_op     = w_is_load || w_is_store;
    assign w_misaligned = w_mem_op && (w_end > 4'd8);
    assign w_go_bus     = w_mem_op && !w_misaligned;

    // Byte-enable pattern for the access size before lane shifting.
    always_comb begin
        w_strb_base = 8'h01;
        case (w_size)
            c_size_b: w_strb_base = 8'h01;
            c_size_h: w_strb_base = 8'h03;
            c_size_w: w_strb_base = 8'h0F;
            c_size_d: w_strb_base = 8'hFF;
            default:  w_strb_base = 8'h01;
        endcase
    end

    assign w_store_wdata   = 64'(stage3_rs2_val) << {w_offset, 3'b000};
    assign w_rdata_shifted = mem_rdata >> {r_offset, 3'b000};

    // Truncate the shifted read data to the access size and extend it.
    always_comb begin
        w_load_value = w_rdata_shifted;
        case (r_size)
            c_size_b: w_load_value = {{56{r_signed && w_rdata_shifted[7]}},  w_rdata_shifted[7:0]};
            c_size_h: w_load_value = {{48{r_signed && w_rdata_shifted[15]}}, w_rdata_shifted[15:0]};
            c_size_w: w_load_value = {{32{r_signed && w_rdata_shifted[31]}}, w_rdata_shifted[31:0]};
            default:  w_load_value = w_rdata_shifted;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE accepts, BUS waits for ack, OUT waits for writeback.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (stage3_valid) begin
                    w_state_next = w_go_bus ? S_BUS : S_OUT;
                end
            end
            S_BUS: begin
                if (mem_ack) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (wb_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers: latch on accept, bus handshake, result delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            mem_addr            <= '0;
            mem_wdata           <= '0;
            mem_wstrb           <= '0;
            nstage4_valid       <= 1'b0;
            nstage4_result      <= '0;
            nstage4_rd          <= '0;
            nstage4_opcode_name <= '0;
            nstage4_pc          <= '0;
            nstage4_misaligned  <= 1'b0;
            r_offset            <= '0;
            r_size              <= '0;
            r_signed            <= 1'b0;
            r_is_load           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        nstage4_opcode_name <= stage3_opcode_name;
                        nstage4_pc          <= stage3_pc;
                        nstage4_misaligned  <= w_misaligned;
                        nstage4_rd          <= (w_is_store || w_misaligned) ? '0 : stage3_rd;
                        nstage4_result      <= w_mem_op ? '0 : stage3_alu_result;
                        r_offset            <= w_offset;
                        r_size              <= w_size;
                        r_signed            <= w_signed;
                        r_is_load           <= w_is_load;
                        if (w_go_bus) begin
                            mem_req   <= 1'b1;
                            mem_we    <= w_is_store;
                            mem_addr  <= BUS_DATA_WIDTH'({stage3_alu_result[REGISTER_WIDTH-1:3], 3'b000});
                            mem_wdata <= w_is_store ? w_store_wdata : '0;
                            mem_wstrb <= w_is_store ? (w_strb_base << w_offset) : '0;
                        end else begin
                            nstage4_valid <= 1'b1;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        nstage4_valid <= 1'b1;
                        if (r_is_load) begin
                            nstage4_result <= REGISTER_WIDTH'(w_load_value);
                        end
                    end
                end
                S_OUT: begin
                    if (wb_ready) begin
                        nstage4_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Self-checking bench for mem_access_stage: directed instructions,
//            a spec-level expectation model and a per-cycle output compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         stage3_valid;
    logic         stage3_ready;
    logic [63:0]  stage3_alu_result;
    logic [63:0]  stage3_rs2_val;
    logic [5:0]   stage3_rd;
    logic [96:0]  stage3_opcode_name;
    logic [63:0]  stage3_pc;
    logic         mem_req;
    logic         mem_we;
    logic [63:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [7:0]   mem_wstrb;
    logic         mem_ack;
    logic [63:0]  mem_rdata;
    logic         nstage4_valid;
    logic         wb_ready;
    logic [63:0]  nstage4_result;
    logic [5:0]   nstage4_rd;
    logic [96:0]  nstage4_opcode_name;
    logic [63:0]  nstage4_pc;
    logic         nstage4_misaligned;

    mem_access_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .stage3_valid        (stage3_valid),
        .stage3_ready        (stage3_ready),
        .stage3_alu_result   (stage3_alu_result),
        .stage3_rs2_val      (stage3_rs2_val),
        .stage3_rd           (stage3_rd),
        .stage3_opcode_name  (stage3_opcode_name),
        .stage3_pc           (stage3_pc),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_wstrb           (mem_wstrb),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .nstage4_valid       (nstage4_valid),
        .wb_ready            (wb_ready),
        .nstage4_result      (nstage4_result),
        .nstage4_rd          (nstage4_rd),
        .nstage4_opcode_name (nstage4_opcode_name),
        .nstage4_pc          (nstage4_pc),
        .nstage4_misaligned  (nstage4_misaligned)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int req_seen = 0;

    // Model expectations for the instruction currently in flight.
    logic         exp_bus = 1'b0;
    logic         exp_we;
    logic [63:0]  exp_addr, exp_wdata, exp_result, exp_pc;
    logic [7:0]   exp_wstrb;
    logic [5:0]   exp_rd;
    logic         exp_mis;
    logic [96:0]  exp_name;

    // Last values observed, used by the literal checks that pin the model.
    logic [63:0]  last_addr, last_wdata, last_result;
    logic [7:0]   last_wstrb;
    logic         last_mis;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int op_size(input string op);
        case (op)
            "lb", "lbu", "sb": return 1;
            "lh", "lhu", "sh": return 2;
            "lw", "lwu", "sw": return 4;
            "ld", "sd":        return 8;
            default:           return 0;
        endcase
    endfunction

    function automatic logic [96:0] to_name(input string op);
        logic [96:0] v = '0;
        for (int i = 0; i < op.len(); i++) v = {v[88:0], op[i]};
        return v;
    endfunction

    // Expected behaviour computed straight from the instruction semantics.
    task automatic set_model(input string op, input logic [63:0] addr, input logic [63:0] rs2,
                             input logic [5:0] rd, input logic [63:0] pc, input logic [63:0] rdata);
        int          sz   = op_size(op);
        bit          ld   = (sz > 0) && (op[0] == "l");
        bit          st   = (sz > 0) && (op[0] == "s");
        bit          sgn  = ld && (op.len() == 2) && (op != "ld");
        int          off  = int'(addr % 64'd8);
        logic [63:0] mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
        logic [63:0] fld;
        exp_mis   = (ld || st) && (off + sz > 8);
        exp_bus   = (ld || st) && !exp_mis;
        exp_we    = st;
        exp_addr  = addr - 64'(off);
        exp_wdata = rs2 << (8 * off);
        exp_wstrb = 8'(((1 << sz) - 1) << off);
        exp_pc    = pc;
        exp_name  = to_name(op);
        if (exp_mis || st) begin
            exp_result = 64'd0;
            exp_rd     = 6'd0;
        end else if (ld) begin
            fld = (rdata >> (8 * off)) & mask;
            if (sgn && fld[8 * sz - 1]) fld = fld | ~mask;
            exp_result = fld;
            exp_rd     = rd;
        end else begin
            exp_result = addr;
            exp_rd     = rd;
        end
    endtask

    // Per-cycle compare of bus and result outputs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req) begin
                req_seen++;
                check("mem_req_allowed", mem_req, exp_bus);
                check("mem_we", mem_we, exp_we);
                check("mem_addr", mem_addr, exp_addr);
                if (exp_we) begin
                    check("mem_wdata", mem_wdata, exp_wdata);
                    check("mem_wstrb", mem_wstrb, exp_wstrb);
                end
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
                last_wstrb = mem_wstrb;
            end
            if (nstage4_valid) begin
                check("result", nstage4_result, exp_result);
                check("rd", nstage4_rd, exp_rd);
                check("misaligned", nstage4_misaligned, exp_mis);
                check("pc", nstage4_pc, exp_pc);
                check("opcode_name", nstage4_opcode_name, exp_name);
                last_result = nstage4_result;
                last_mis    = nstage4_misaligned;
            end
            check("stage3_ready", stage3_ready, !(mem_req || nstage4_valid));
        end
    end

    // Issue one instruction from posedge+1, answer the bus, drain to writeback.
    task automatic do_instr(input string op, input logic [63:0] addr, input logic [63:0] rs2,
                            input logic [5:0] rd, input logic [63:0] pc, input int delay,
                            input logic [63:0] rdata, input int hold);
        int rs0;
        set_model(op, addr, rs2, rd, pc, rdata);
        check("ready_before_accept", stage3_ready, 1'b1);
        stage3_valid       = 1'b1;
        stage3_alu_result  = addr;
        stage3_rs2_val     = rs2;
        stage3_rd          = rd;
        stage3_pc          = pc;
        stage3_opcode_name = to_name(op);
        rs0 = req_seen;
        @(posedge clk); #1;
        stage3_valid = 1'b0;
        if (exp_bus) begin
            for (int i = 1; i < delay; i++) begin
                @(posedge clk); #1;
            end
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            check("req_seen", req_seen != rs0, 1'b1);
        end
        check("valid_latency", nstage4_valid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("held_valid", nstage4_valid, 1'b1);
            check("held_ready", stage3_ready, 1'b0);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        check("valid_drop", nstage4_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        stage3_valid = 1'b0; stage3_alu_result = '0; stage3_rs2_val = '0;
        stage3_rd = '0; stage3_opcode_name = '0; stage3_pc = '0;
        mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", stage3_ready, 1'b1);
        check("rst_req", mem_req, 1'b0);
        check("rst_valid", nstage4_valid, 1'b0);
        check("rst_result", nstage4_result, 64'd0);
        check("rst_wstrb", mem_wstrb, 8'd0);
        check("rst_mis", nstage4_misaligned, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_instr("addi", 64'h2A, 64'h0, 6'd5, 64'h100, 1, 64'h0, 0);
        check("lit_addi", last_result, 64'h2A);

        do_instr("sw", 64'h1004, 64'hDEADBEEF, 6'd7, 64'h104, 3, 64'h0, 0);
        check("lit_sw_addr", last_addr, 64'h1000);
        check("lit_sw_wstrb", last_wstrb, 8'hF0);
        check("lit_sw_wdata", last_wdata, 64'hDEADBEEF_00000000);
        check("lit_sw_result", last_result, 64'h0);

        do_instr("lb", 64'h2003, 64'h0, 6'd8, 64'h108, 2, 64'h00000000_80000000, 0);
        check("lit_lb", last_result, 64'hFFFFFFFF_FFFFFF80);
        do_instr("lbu", 64'h2003, 64'h0, 6'd9, 64'h10C, 1, 64'h00000000_80000000, 0);
        check("lit_lbu", last_result, 64'h80);

        do_instr("lw", 64'h3006, 64'h0, 6'd10, 64'h110, 1, 64'h0, 0);
        check("lit_lw_mis", last_mis, 1'b1);

        // Writeback stall, then back-to-back accepts.
        do_instr("ld", 64'h4000, 64'h0, 6'd11, 64'h114, 2, 64'h12345678_9ABCDEF0, 4);
        do_instr("sh", 64'h5006, 64'hBEEF, 6'd12, 64'h118, 1, 64'h0, 0);
        check("lit_sh_wstrb", last_wstrb, 8'hC0);
        do_instr("sd", 64'h5008, 64'h0123_4567_89AB_CDEF, 6'd13, 64'h11C, 4, 64'h0, 0);
        do_instr("lh", 64'h6002, 64'h0, 6'd14, 64'h120, 1, 64'h00000000_80010000, 0);
        check("lit_lh", last_result, 64'hFFFFFFFF_FFFF8001);
        do_instr("lwu", 64'h6004, 64'h0, 6'd15, 64'h124, 2, 64'hF0000000_00000000, 0);
        do_instr("lhu", 64'h6007, 64'h0, 6'd16, 64'h128, 1, 64'h0, 0);
        do_instr("sd", 64'h5001, 64'h55, 6'd17, 64'h12C, 1, 64'h0, 0);
        do_instr("sb", 64'h7007, 64'hA5, 6'd18, 64'h130, 1, 64'h0, 0);
        do_instr("foo", 64'hCAFE, 64'h0, 6'd19, 64'h134, 1, 64'h0, 0);

        // Reset in the middle of a bus transaction, then a stray ack.
        set_model("sw", 64'h7000, 64'h11, 6'd3, 64'h140, 64'h0);
        stage3_valid = 1'b1; stage3_alu_result = 64'h7000; stage3_rs2_val = 64'h11;
        stage3_rd = 6'd3; stage3_pc = 64'h140; stage3_opcode_name = to_name("sw");
        @(posedge clk); #1;
        stage3_valid = 1'b0;
        @(posedge clk); #1;
        check("bus_req_before_rst", mem_req, 1'b1);
        #2;
        reset   = 1'b1;
        exp_bus = 1'b0;
        #1;
        check("async_rst_req", mem_req, 1'b0);
        check("async_rst_ready", stage3_ready, 1'b1);
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            check("stray_ack_ready", stage3_ready, 1'b1);
            check("stray_ack_valid", nstage4_valid, 1'b0);
            check("stray_ack_req", mem_req, 1'b0);
            @(posedge clk); #1;
        end

        do_instr("add", 64'h77, 64'h0, 6'd1, 64'h144, 1, 64'h0, 0);
        check("lit_after_rst", last_result, 64'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
